// File: rtl/npc_redirect_ctrl.sv
// Control-transfer initiator beside MEM: resolves branch/jal/jalr, drives NPCOp/j_fetch
// and squashes younger slots. Optional statistics counters under NPC_REDIRECT_STATS_EN.
module npc_redirect_ctrl #(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_branch,
    input  logic             mem_taken,
    input  logic             mem_jal,
    input  logic             mem_jalr,
    input  logic             fetch_stall,
    input  logic             hazard_stall,
    output logic [2:0]       NPCOp,
    output logic             j_fetch,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
`ifdef NPC_REDIRECT_STATS_EN
    output logic             redirect_busy,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] taken_br_cnt
`else
    output logic             redirect_busy
`endif
);

    // NPC operation encodings shared with the NPC unit
    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam int SW = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES + 1) : 1;
    localparam logic [SW-1:0] CNT_INIT = SW'(SHADOW_CYCLES);

    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SHADOW = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [2:0]    pend_op_q, pend_op_d;
    logic          take;
    logic [2:0]    sel_op;
    logic          flush_all;
    logic          issue;

    always_comb begin
        take   = mem_valid & ((mem_branch & mem_taken) | mem_jal | mem_jalr);
        sel_op = mem_jalr ? NPC_JALR : (mem_jal ? NPC_JUMP : NPC_BRANCH);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_op_d = pend_op_q;
        NPCOp     = NPC_PLUS4;
        j_fetch   = fetch_stall | hazard_stall;
        flush_all = 1'b0;
        issue     = 1'b0;

        case (state_q)
            IDLE: begin
                if (take && !fetch_stall) begin
                    // Redirect wins over a load-use hold: the held slot is squashed anyway
                    NPCOp     = sel_op;
                    j_fetch   = 1'b0;
                    flush_all = 1'b1;
                    issue     = 1'b1;
                end else if (take) begin
                    j_fetch   = 1'b1;
                    pend_op_d = sel_op;
                    state_d   = PEND;
                end
            end
            PEND: begin
                if (!fetch_stall) begin
                    NPCOp     = pend_op_q;
                    j_fetch   = 1'b0;
                    flush_all = 1'b1;
                    issue     = 1'b1;
                    pend_op_d = NPC_PLUS4;
                end else begin
                    j_fetch = 1'b1;
                end
            end
            SHADOW: begin
                if (!fetch_stall) begin
                    if (cnt_q <= SW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (issue) begin
            if (SHADOW_CYCLES == 0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHADOW;
                cnt_d   = CNT_INIT;
            end
        end

        if (rst) begin
            NPCOp     = NPC_PLUS4;
            j_fetch   = 1'b1;
            flush_all = 1'b0;
            issue     = 1'b0;
        end

        flush_if_id   = flush_all;
        flush_id_ex   = flush_all;
        flush_ex_mem  = flush_all;
        redirect_busy = !rst && (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_op_q <= NPC_PLUS4;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_op_q <= pend_op_d;
        end
    end

`ifdef NPC_REDIRECT_STATS_EN
    logic [CNT_W-1:0] redirect_cnt_q;
    logic [CNT_W-1:0] taken_br_cnt_q;

    // Counters wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt_q <= '0;
            taken_br_cnt_q <= '0;
        end else if (issue) begin
            redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            if (NPCOp == NPC_BRANCH) begin
                taken_br_cnt_q <= taken_br_cnt_q + CNT_W'(1);
            end
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign taken_br_cnt = taken_br_cnt_q;
`endif

endmodule

// File: tb/tb_npc_redirect_ctrl.sv
// Self-checking bench for npc_redirect_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_npc_redirect_ctrl;

    localparam int SC    = 2;
    localparam int CNT_W = 2;

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JALR   = 3'b100;

    logic clk = 1'b0;
    logic rst, mem_valid, mem_branch, mem_taken, mem_jal, mem_jalr;
    logic fetch_stall, hazard_stall;
    logic [2:0] NPCOp;
    logic j_fetch, flush_if_id, flush_id_ex, flush_ex_mem, redirect_busy;
`ifdef NPC_REDIRECT_STATS_EN
    logic [CNT_W-1:0] redirect_cnt, taken_br_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    npc_redirect_ctrl #(.SHADOW_CYCLES(SC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_branch(mem_branch), .mem_taken(mem_taken),
        .mem_jal(mem_jal), .mem_jalr(mem_jalr),
        .fetch_stall(fetch_stall), .hazard_stall(hazard_stall),
        .NPCOp(NPCOp), .j_fetch(j_fetch),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
`ifdef NPC_REDIRECT_STATS_EN
        .redirect_cnt(redirect_cnt), .taken_br_cnt(taken_br_cnt),
`endif
        .redirect_busy(redirect_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a pending redirect waits for fetch to unstall; afterwards a number
    // of unstalled cycles must pass before MEM may redirect again.
    bit         m_pending = 0;
    logic [2:0] m_pend_op = OP_PLUS4;
    int         m_block   = 0;
    int         m_redirects = 0;
    int         m_branches  = 0;

    always @(negedge clk) begin : compare
        logic [2:0] eop, want;
        logic       ej, efl, ebusy, issued, tk;
        tk   = mem_valid & ((mem_branch & mem_taken) | mem_jal | mem_jalr);
        want = mem_jalr ? OP_JALR : (mem_jal ? OP_JUMP : OP_BRANCH);
        eop = OP_PLUS4; ej = fetch_stall | hazard_stall; efl = 0; issued = 0;
        ebusy = m_pending || (m_block > 0);
        if (rst) begin
            ej = 1; ebusy = 0;
        end else if (m_pending) begin
            if (fetch_stall) ej = 1;
            else begin eop = m_pend_op; ej = 0; efl = 1; issued = 1; end
        end else if (m_block > 0) begin
            // window: nothing but the default hold behaviour
        end else if (tk) begin
            if (fetch_stall) ej = 1;
            else begin eop = want; ej = 0; efl = 1; issued = 1; end
        end
        chk("npcop", 32'(NPCOp), 32'(eop));
        chk("j_fetch", 32'(j_fetch), 32'(ej));
        chk("flush_if_id", 32'(flush_if_id), 32'(efl));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(efl));
        chk("flush_ex_mem", 32'(flush_ex_mem), 32'(efl));
        chk("busy", 32'(redirect_busy), 32'(ebusy));
`ifdef NPC_REDIRECT_STATS_EN
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_redirects % (1 << CNT_W)));
        chk("taken_br_cnt", 32'(taken_br_cnt), 32'(m_branches % (1 << CNT_W)));
`endif
        if (rst) begin
            m_pending = 0; m_pend_op = OP_PLUS4; m_block = 0;
            m_redirects = 0; m_branches = 0;
        end else if (issued) begin
            m_pending = 0; m_block = SC;
            m_redirects++;
            if (eop == OP_BRANCH) m_branches++;
        end else if (m_pending) begin
            // still waiting
        end else if (m_block > 0) begin
            if (!fetch_stall) m_block--;
        end else if (tk) begin
            m_pending = 1; m_pend_op = want;
        end
    end

    // Drive one cycle of inputs just after the edge; returns mid-cycle for literal checks
    task automatic drv(input logic r, input logic v, input logic b, input logic t,
                       input logic j, input logic jr, input logic fs, input logic hs);
        @(posedge clk);
        #1;
        rst = r; mem_valid = v; mem_branch = b; mem_taken = t;
        mem_jal = j; mem_jalr = jr; fetch_stall = fs; hazard_stall = hs;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; mem_valid = 0; mem_branch = 0; mem_taken = 0;
        mem_jal = 0; mem_jalr = 0; fetch_stall = 0; hazard_stall = 0;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_j_fetch", 32'(j_fetch), 32'd1);
        chk("rst_busy", 32'(redirect_busy), 32'd0);
        drv(1, 1, 0, 0, 1, 0, 0, 0);
        chk("rst_npcop", 32'(NPCOp), 32'(OP_PLUS4));
        chk("rst_flush", 32'(flush_if_id), 32'd0);

        // jal redirects at once, then two cycles of shadow ignore it
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        chk("jal_op", 32'(NPCOp), 32'(OP_JUMP));
        chk("jal_jf", 32'(j_fetch), 32'd0);
        chk("jal_fl", 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'd7);
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        chk("shadow1_op", 32'(NPCOp), 32'(OP_PLUS4));
        chk("shadow1_fl", 32'(flush_if_id), 32'd0);
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        chk("shadow2_op", 32'(NPCOp), 32'(OP_PLUS4));
        drv(0, 1, 0, 0, 1, 0, 0, 0);
        chk("after_shadow_op", 32'(NPCOp), 32'(OP_JUMP));
        idle(2);

        // branch not taken, then taken
        drv(0, 1, 1, 0, 0, 0, 0, 0);
        chk("bnt_op", 32'(NPCOp), 32'(OP_PLUS4));
        chk("bnt_fl", 32'(flush_ex_mem), 32'd0);
        drv(0, 1, 1, 1, 0, 0, 0, 0);
        chk("bt_op", 32'(NPCOp), 32'(OP_BRANCH));
        chk("bt_fl", 32'(flush_id_ex), 32'd1);
        idle(2);

        // jalr deferred by fetch stall
        drv(0, 1, 0, 0, 0, 1, 1, 0);
        chk("pend1_jf", 32'(j_fetch), 32'd1);
        chk("pend1_fl", 32'(flush_if_id), 32'd0);
        drv(0, 1, 0, 0, 0, 1, 1, 0);
        chk("pend2_busy", 32'(redirect_busy), 32'd1);
        drv(0, 1, 0, 0, 0, 1, 1, 0);
        chk("pend3_busy", 32'(redirect_busy), 32'd1);
        chk("pend3_op", 32'(NPCOp), 32'(OP_PLUS4));
        drv(0, 1, 0, 0, 0, 1, 0, 0);
        chk("pend_rel_op", 32'(NPCOp), 32'(OP_JALR));
        chk("pend_rel_fl", 32'(flush_ex_mem), 32'd1);
        idle(2);

        // redirect beats hazard stall; hazard alone holds fetch
        drv(0, 1, 0, 0, 1, 0, 0, 1);
        chk("hz_take_jf", 32'(j_fetch), 32'd0);
        chk("hz_take_op", 32'(NPCOp), 32'(OP_JUMP));
        idle(2);
        drv(0, 0, 0, 0, 0, 0, 0, 1);
        chk("hz_only_jf", 32'(j_fetch), 32'd1);
        chk("hz_only_op", 32'(NPCOp), 32'(OP_PLUS4));

        // reset while pending discards the op
        drv(0, 1, 0, 0, 0, 1, 1, 0);
        drv(1, 1, 0, 0, 0, 1, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstpend_busy", 32'(redirect_busy), 32'd0);
        chk("rstpend_op", 32'(NPCOp), 32'(OP_PLUS4));
        chk("rstpend_fl", 32'(flush_if_id), 32'd0);

        // five taken branches after reset
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, 1, 1, 0, 0, 0, 0);
            idle(2);
        end
`ifdef NPC_REDIRECT_STATS_EN
        chk("stat_br_wrap", 32'(taken_br_cnt), 32'd1);
        chk("stat_red_wrap", 32'(redirect_cnt), 32'd1);
`endif

        for (int i = 0; i < 4000; i++) begin
            drv(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
